// File: rtl/data_register_assembler.sv
// data_register_assembler
// Byte-loaded data register that sits between the byte-wide memory data bus
// and the ALU/address datapath. Two ways to load it:
//  - direct mode: one FunSel operation per enabled cycle (extend or shift in I)
//  - assembly mode: collect 1..NBYTES bytes over a valid/ready handshake, then
//    zero/sign-extend the field and publish it to DROut in a single edge.
// DROut never shows a half-assembled word; partial bytes live in acc_q.

module data_register_assembler #(
    parameter  int DATA_W     = 32,
    parameter  int BYTE_W     = 8,
    parameter  int BIG_ENDIAN = 0,
    localparam int NBYTES     = DATA_W / BYTE_W,
    localparam int CW         = $clog2(NBYTES + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              E,
    input  logic [1:0]        FunSel,
    input  logic [BYTE_W-1:0] I,
    input  logic              Start,
    input  logic [CW-1:0]     Len,
    input  logic              Sext,
    input  logic              Abort,
    input  logic              IValid,
    output logic              IReady,
    output logic              Busy,
    output logic              Done,
    output logic [CW-1:0]     Count,
    output logic [DATA_W-1:0] DROut
);

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } state_t;

    localparam logic [CW-1:0] NB_C = CW'(NBYTES);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   dr_q, dr_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       lq_q, lq_d;
    logic                sext_q, sext_d;
    logic                done_d;
    logic                done_q;

    // Accumulator with the current byte merged in, and its extended form.
    logic [DATA_W-1:0]   acc_wr;
    logic [DATA_W-1:0]   ext_val;
    logic                sign_bit;
    logic                last_byte;
    int                  lane;
    int                  field_bits;

    // Merge I into the target lane and build the extended result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_wr     = acc_q;
        ext_val    = '0;
        sign_bit   = 1'b0;
        lane       = (BIG_ENDIAN != 0) ? (int'(lq_q) - 1 - int'(cnt_q)) : int'(cnt_q);
        field_bits = int'(lq_q) * BYTE_W;
        for (int l = 0; l < NBYTES; l++) begin
            if (l == lane) begin
                acc_wr[l*BYTE_W +: BYTE_W] = I;
            end
        end
        for (int b = 0; b < DATA_W; b++) begin
            if (b == field_bits - 1) begin
                sign_bit = acc_wr[b];
            end
        end
        for (int b = 0; b < DATA_W; b++) begin
            ext_val[b] = (b < field_bits) ? acc_wr[b] : (sext_q & sign_bit);
        end
    end

    assign last_byte = (cnt_q == (lq_q - CW'(1)));

    // Next-state, register and accumulator update logic.
    always_comb begin
        state_d = state_q;
        dr_d    = dr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lq_d    = lq_q;
        sext_d  = sext_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    lq_d    = ((Len == '0) || (Len > NB_C)) ? NB_C : Len;
                    sext_d  = Sext;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ASSEMBLE;
                end else if (E) begin
                    case (FunSel)
                        2'b00:   dr_d = {{(DATA_W-BYTE_W){I[BYTE_W-1]}}, I};
                        2'b01:   dr_d = {{(DATA_W-BYTE_W){1'b0}}, I};
                        2'b10:   dr_d = {dr_q[DATA_W-BYTE_W-1:0], I};
                        default: dr_d = {I, dr_q[DATA_W-1:BYTE_W]};
                    endcase
                end
            end
            ASSEMBLE: begin
                if (Abort) begin
                    // Abort wins over any transfer, including the last byte.
                    state_d = IDLE;
                end else if (IValid) begin
                    acc_d = acc_wr;
                    cnt_d = cnt_q + CW'(1);
                    if (last_byte) begin
                        dr_d    = ext_val;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-assembly.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            dr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            lq_q    <= '0;
            sext_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            dr_q    <= dr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            lq_q    <= lq_d;
            sext_q  <= sext_d;
            done_q  <= done_d;
        end
    end

    assign Busy   = (state_q == ASSEMBLE);
    assign IReady = (state_q == ASSEMBLE);
    assign Done   = done_q;
    assign Count  = cnt_q;
    assign DROut  = dr_q;

endmodule

// File: doc/data_register_assembler.md
Name: data_register_assembler

Overview:
Parametrised successor of the 32-bit byte-loaded data register. Keeps the direct per-cycle FunSel load and shift modes, generalised to DATA_W/BYTE_W. Adds an autonomous assembly mode that collects 1..NBYTES bytes from the memory byte bus over a valid/ready handshake. The result is zero- or sign-extended and published atomically. Sits between the byte-wide memory data bus and the ALU/address datapath.

Parameters:
DATA_W, 32, register width; must be an integer multiple of BYTE_W and at least 2*BYTE_W
BYTE_W, 8, width of the input byte bus
BIG_ENDIAN, 0, assembly order: 0 = first byte to least significant lane, 1 = first byte to most significant lane of the assembled field
(derived) NBYTES = DATA_W/BYTE_W; CW = clog2(NBYTES+1)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
E  in  1  direct-mode enable
FunSel  in  2  direct-mode function
I  in  BYTE_W  input byte (both modes)
Start  in  1  begin assembly (1-cycle pulse)
Len  in  CW  byte count for assembly, sampled on Start
Sext  in  1  1 = sign-extend assembled field, 0 = zero-extend; sampled on Start
Abort  in  1  cancel assembly
IValid  in  1  byte on I is valid (assembly mode)
IReady  out  1  block accepts a byte this cycle
Busy  out  1  assembly in progress
Done  out  1  1-cycle pulse: DROut just updated by assembly
Count  out  CW  bytes accepted in the current assembly
DROut  out  DATA_W  register value

Behaviour:
- Reset (Reset=0, async): DROut=0, Count=0, Busy=0, Done=0, IReady=0, state=IDLE, accumulator=0, latched Len/Sext=0. This applies at any time, including mid-assembly.
- States: IDLE, ASSEMBLE. Busy=IReady=(state==ASSEMBLE); both are decoded from registered state only.
- IDLE, priority Start > E:
  - Start=1: latch Lq = (Len==0 || Len>NBYTES) ? NBYTES : Len; latch Sext; clear accumulator and Count; go to ASSEMBLE next cycle. DROut is unchanged. E is ignored in that cycle.
  - E=1, Start=0, FunSel:
    - 00: DROut <= sign-extend(I).
    - 01: DROut <= zero-extend(I).
    - 10: DROut <= {DROut[DATA_W-BYTE_W-1:0], I}.
    - 11: DROut <= {I, DROut[DATA_W-1:BYTE_W]}.
    - With DATA_W=32, BYTE_W=8 this is bit-identical to the existing data register.
  - E=0 and Start=0: hold.
- ASSEMBLE:
  - Start and E are ignored.
  - Transfer occurs when IValid && IReady. I is written into byte lane k = Count (BIG_ENDIAN=0) or lane Lq-1-Count (BIG_ENDIAN=1) of the accumulator. Count increments.
  - IValid=0: no change, no timeout.
  - Transfer with Count==Lq-1 (last byte):
    - DROut <= extend(accumulator including this byte, Lq*BYTE_W bits, Sext), in the same edge.
    - Done=1 for the following cycle only.
    - state -> IDLE.
    - Count holds Lq until the next Start.
  - Sext=1: bit Lq*BYTE_W-1 is replicated up to the MSB. Lq=NBYTES means no extension.
  - DROut never shows partial assembly; it changes only on completion.
- Abort=1 in ASSEMBLE: go to IDLE next cycle. No Done. DROut unchanged. A transfer in the same cycle is discarded. Abort has priority over the last-byte transfer. Abort in IDLE has no effect.
- Minimum latency: Start at cycle 0, bytes at cycles 1..Lq, DROut valid and Done high in cycle Lq+1. A new Start is accepted in the same cycle Done is high.

Test Plan:
- Direct mode, DATA_W=32: reset; E=1,FunSel=00,I=0x85 -> DROut=0xFFFFFF85. FunSel=01,I=0x85 -> 0x00000085. FunSel=10,I=0x12 -> 0x00008512. FunSel=11,I=0xAB -> 0xAB000085.
- Little-endian assembly: Start, Len=4; bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> DROut=0x44332211, Done one cycle, Count=4. DROut unchanged at 0xAB000085 before Done.
- Assembly with sign extension and stalls: Start, Len=2, Sext=1; bytes 0x80 then 0xFF, with IValid low for 3 cycles between them -> DROut=0xFFFFFF80, Busy high for 5 cycles. Repeat with BIG_ENDIAN=1 -> 0xFFFF80FF.
- Length boundaries: Len=0 -> 4 bytes accepted. Len=7 -> clamped to 4. Len=1, Sext=0, byte 0xF0 -> DROut=0x000000F0.
- Abort and interference: Abort after 2 of 4 bytes -> no Done, DROut unchanged. E=1 and Start pulses during ASSEMBLE are ignored. Abort on the last-byte cycle -> no update.
- Async reset mid-assembly: Reset=0 between clock edges -> DROut=0, Busy=0, Count=0 immediately. After release the next Start works normally.
